opc_bus_arbiter: RTL and testbench
==================================

OPC_BUS_ARBITER -- requirements
Module: opc_bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, giving the number of slave-access cycles per transfer (legal range 1..15).
REQ-002 SHALL have parameter RAM_AWIDTH, default 11, giving the RAM word-address width; the RAM window is 0x0000..(2^RAM_AWIDTH-1).
REQ-003 SHALL have ports clk (in, 1, sole clock, rising edge) and reset (in, 1, asynchronous, active-high).
REQ-004 SHALL have per-requester ports m0_/m1_ req (in, 1), addr (in, 16), wdata (in, 16), rnw (in, 1, 1=read), ack (out, 1), rdata (out, 16); m0 is the CPU and m1 is the DMA/loader.
REQ-005 SHALL have slave ports s_addr (out, 16), s_wdata (out, 16), s_rnw (out, 1), ram_cs_b (out, 1, low-active), uart_cs_b (out, 1, low-active) and s_rdata (in, 16).
REQ-006 SHALL have output bus_err (out, 1), a one-cycle pulse on an unmapped access.

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-008 In IDLE, on a rising clk edge with any req high, SHALL latch the winner's addr/wdata/rnw, set the grant and enter ACCESS.
REQ-009 SHALL arbitrate round-robin: when both requests are high, the requester not granted last wins; the last-grant pointer resets to m1 so m0 wins the first tie.
REQ-010 In ACCESS, SHALL drive the latched s_addr/s_wdata/s_rnw and the decoded chip select for exactly WAIT_CYCLES cycles, counted by a 4-bit counter.
REQ-011 Decode: ram_cs_b=0 when addr[15:RAM_AWIDTH]==0; uart_cs_b=0 when addr[15:1]==0xFE08>>1; otherwise the access is unmapped.
REQ-012 On the final ACCESS cycle, SHALL capture s_rdata (reads) into the granted requester's rdata register and enter DONE.
REQ-013 In DONE, SHALL assert the granted requester's ack for exactly one cycle, then return to IDLE; ack latency is WAIT_CYCLES+1 cycles after the sampling edge.
REQ-014 Outside ACCESS, both chip selects SHALL be 1 and s_rnw SHALL be 1.
REQ-015 An unmapped access SHALL still run the full ACCESS/DONE sequence with no chip select asserted, return rdata 0xFFFF, and pulse bus_err coincident with ack.
REQ-016 Requesters SHALL hold req and request fields stable until ack; the arbiter SHALL ignore changes to them after the IDLE sampling edge.
REQ-017 rdata SHALL hold its last value until the next read completion for that requester; a write SHALL leave rdata unchanged.
REQ-018 Back-to-back transfers SHALL include at least one IDLE cycle between DONE and the next ACCESS.

Reset
REQ-019 While reset is asserted, SHALL force state IDLE, ack=0, bus_err=0, chip selects=1, s_rnw=1, s_addr=0, s_wdata=0, rdata=0, counter=0 and last-grant=m1, regardless of clk.
REQ-020 Reset asserted mid-ACCESS SHALL abort the transfer immediately with no ack; after release, pending requests SHALL be re-arbitrated from IDLE.

Configuration
REQ-021 With OPC_ARB_LOCK_EN defined, SHALL add inputs m0_lock and m1_lock (1 bit each); a requester holding lock high at its ack SHALL win the next IDLE arbitration over round-robin, provided its req is high.
REQ-022 Without OPC_ARB_LOCK_EN, the lock ports SHALL be absent and arbitration SHALL be pure round-robin.

Structure
REQ-023 Package opc_bus_pkg SHALL hold the FSM state typedef, the UART base 0xFE08 and the unmapped read value 0xFFFF.
REQ-024 SHALL contain one sub-module, opc_addr_decode, which maps addr to {ram_cs_b, uart_cs_b, unmapped} combinationally.

Verification
REQ-025 m0 reads 0x0010 with WAIT_CYCLES=1 and s_rdata=0x1234 -> ram_cs_b low for 1 cycle, m0_ack 2 cycles after the sampling edge, m0_rdata=0x1234.
REQ-026 m0 and m1 request in the same cycle out of reset -> m0 is served first, then m1 after one IDLE cycle; a repeated tie -> m1 then m0 (alternating).
REQ-027 m1 writes 0x0041 to 0xFE09 -> uart_cs_b low, s_rnw=0, s_wdata=0x0041, ram_cs_b stays high.
REQ-028 m0 reads 0x9000 -> no chip select asserted, m0_rdata=0xFFFF, bus_err pulses with m0_ack.
REQ-029 reset asserted in the 2nd ACCESS cycle with WAIT_CYCLES=3 -> no ack, all outputs at reset values; after release with req held high -> transfer restarts and completes normally.
REQ-030 With OPC_ARB_LOCK_EN defined, m1_lock held high and both requesters continuously requesting -> m1 wins every arbitration until lock drops, then m0 wins next.

Source files
------------

// File: rtl/opc_bus_pkg.sv
// Shared types and constants for the OPC bus arbiter and its address decoder.
package opc_bus_pkg;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    // UART occupies two words starting here
    localparam logic [15:0] UartBase = 16'hFE08;

    // Read data returned for an access that hits no slave
    localparam logic [15:0] UnmappedRdata = 16'hFFFF;

endpackage

// File: rtl/opc_addr_decode.sv
// Combinational address decoder: RAM window at the bottom of the map, UART pair at UartBase,
// everything else unmapped.
module opc_addr_decode
    import opc_bus_pkg::*;
#(
    parameter int unsigned RAM_AWIDTH = 11
) (
    input  logic [15:0] addr,
    output logic        ram_cs_b,
    output logic        uart_cs_b,
    output logic        unmapped
);

    logic ram_hit;
    logic uart_hit;

    // RAM wins if a wide RAM window ever overlaps the UART pair
    always_comb begin
        ram_hit   = ((addr >> RAM_AWIDTH) == 16'h0000);
        uart_hit  = (addr[15:1] == UartBase[15:1]) && !ram_hit;
        ram_cs_b  = !ram_hit;
        uart_cs_b = !uart_hit;
        unmapped  = !ram_hit && !uart_hit;
    end

endmodule

// File: rtl/opc_bus_arbiter.sv
// Two-master (CPU m0, DMA/loader m1) round-robin bus arbiter with a fixed-length slave access.
// Each transfer runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE (one-cycle ack) -> IDLE.
// Optional build macro OPC_ARB_LOCK_EN adds m0_lock/m1_lock: a master holding lock at its ack
// keeps the bus for its next request.
module opc_bus_arbiter
    import opc_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned RAM_AWIDTH  = 11
) (
    input  logic        clk,
    input  logic        reset,
    // CPU requester
    input  logic        m0_req,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    input  logic        m0_rnw,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    // DMA / loader requester
    input  logic        m1_req,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic        m1_rnw,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
`ifdef OPC_ARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    // Slave side
    output logic [15:0] s_addr,
    output logic [15:0] s_wdata,
    output logic        s_rnw,
    output logic        ram_cs_b,
    output logic        uart_cs_b,
    input  logic [15:0] s_rdata,
    output logic        bus_err
);

    localparam logic [3:0] CntLast = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_q, grant_d;   // 0 = m0, 1 = m1
    logic        last_q, last_d;     // last granted requester, same encoding
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rnw_q, rnw_d;
    logic [15:0] m0_rdata_q, m0_rdata_d;
    logic [15:0] m1_rdata_q, m1_rdata_d;
`ifdef OPC_ARB_LOCK_EN
    logic        lock_pend_q, lock_pend_d;  // last_q held lock at its ack
`endif

    logic        winner;
    logic        dec_ram_cs_b;
    logic        dec_uart_cs_b;
    logic        dec_unmapped;
    logic        in_access;

    // Decode the latched address so mid-transfer request changes cannot glitch the selects
    opc_addr_decode #(
        .RAM_AWIDTH (RAM_AWIDTH)
    ) u_decode (
        .addr      (addr_q),
        .ram_cs_b  (dec_ram_cs_b),
        .uart_cs_b (dec_uart_cs_b),
        .unmapped  (dec_unmapped)
    );

    // Pick the next owner: lock holder first, then round-robin on a tie
    always_comb begin
        if (m0_req && m1_req) begin
            winner = ~last_q;
        end else begin
            winner = m1_req;
        end
`ifdef OPC_ARB_LOCK_EN
        if (lock_pend_q && (last_q ? m1_req : m0_req)) begin
            winner = last_q;
        end
`endif
    end

    // Sequencer next-state, request latching and read-data capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rnw_d      = rnw_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
`ifdef OPC_ARB_LOCK_EN
        lock_pend_d = lock_pend_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    state_d = StAccess;
                    cnt_d   = 4'd0;
                    grant_d = winner;
                    last_d  = winner;
                    addr_d  = winner ? m1_addr  : m0_addr;
                    wdata_d = winner ? m1_wdata : m0_wdata;
                    rnw_d   = winner ? m1_rnw   : m0_rnw;
`ifdef OPC_ARB_LOCK_EN
                    lock_pend_d = 1'b0;
`endif
                end
            end
            StAccess: begin
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    cnt_d   = 4'd0;
                    if (rnw_q) begin
                        if (grant_q) begin
                            m1_rdata_d = dec_unmapped ? UnmappedRdata : s_rdata;
                        end else begin
                            m0_rdata_d = dec_unmapped ? UnmappedRdata : s_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
`ifdef OPC_ARB_LOCK_EN
                lock_pend_d = grant_q ? m1_lock : m0_lock;
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            rnw_q      <= 1'b1;
            m0_rdata_q <= 16'h0000;
            m1_rdata_q <= 16'h0000;
`ifdef OPC_ARB_LOCK_EN
            lock_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rnw_q      <= rnw_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
`ifdef OPC_ARB_LOCK_EN
            lock_pend_q <= lock_pend_d;
`endif
        end
    end

    // Slave strobes only during ACCESS; ack and bus_err only during DONE
    always_comb begin
        in_access = (state_q == StAccess);
        s_addr    = addr_q;
        s_wdata   = wdata_q;
        s_rnw     = in_access ? rnw_q : 1'b1;
        ram_cs_b  = in_access ? dec_ram_cs_b : 1'b1;
        uart_cs_b = in_access ? dec_uart_cs_b : 1'b1;
        m0_ack    = (state_q == StDone) && !grant_q;
        m1_ack    = (state_q == StDone) && grant_q;
        bus_err   = (state_q == StDone) && dec_unmapped;
        m0_rdata  = m0_rdata_q;
        m1_rdata  = m1_rdata_q;
    end

endmodule

// File: tb/tb_opc_bus_arbiter.sv
// Directed self-checking bench for opc_bus_arbiter. u_dut uses WAIT_CYCLES=1, u_dut3 uses
// WAIT_CYCLES=3; both share stimulus. Inputs change and outputs are sampled on the falling edge.
module tb_opc_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [15:0] m0_addr = 16'h0, m0_wdata = 16'h0, m1_addr = 16'h0, m1_wdata = 16'h0;
    logic        m0_rnw = 1'b1, m1_rnw = 1'b1;
    logic [15:0] s_rdata = 16'h0;
`ifdef OPC_ARB_LOCK_EN
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
`endif

    logic        m0_ack, m1_ack, s_rnw, ram_cs_b, uart_cs_b, bus_err;
    logic [15:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic        m0_ack_3, m1_ack_3, s_rnw_3, ram_cs_b_3, uart_cs_b_3, bus_err_3;
    logic [15:0] m0_rdata_3, m1_rdata_3, s_addr_3, s_wdata_3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    opc_bus_arbiter u_dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rnw    (m0_rnw),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rnw    (m1_rnw),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
`ifdef OPC_ARB_LOCK_EN
        .m0_lock   (m0_lock),
        .m1_lock   (m1_lock),
`endif
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rnw     (s_rnw),
        .ram_cs_b  (ram_cs_b),
        .uart_cs_b (uart_cs_b),
        .s_rdata   (s_rdata),
        .bus_err   (bus_err)
    );

    opc_bus_arbiter #(
        .WAIT_CYCLES (3)
    ) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rnw    (m0_rnw),
        .m0_ack    (m0_ack_3),
        .m0_rdata  (m0_rdata_3),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rnw    (m1_rnw),
        .m1_ack    (m1_ack_3),
        .m1_rdata  (m1_rdata_3),
`ifdef OPC_ARB_LOCK_EN
        .m0_lock   (m0_lock),
        .m1_lock   (m1_lock),
`endif
        .s_addr    (s_addr_3),
        .s_wdata   (s_wdata_3),
        .s_rnw     (s_rnw_3),
        .ram_cs_b  (ram_cs_b_3),
        .uart_cs_b (uart_cs_b_3),
        .s_rdata   (s_rdata),
        .bus_err   (bus_err_3)
    );

    // Pulse reset for two cycles with requests idle; returns at the falling edge of release
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        m0_req = 1'b1;
        m0_addr = 16'h0010;
        #1;
        checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL reset_m0_ack got=%b exp=0", m0_ack); end
        checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL reset_m1_ack got=%b exp=0", m1_ack); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
        checks++; if ({ram_cs_b, uart_cs_b, s_rnw} !== 3'b111) begin errors++; $display("FAIL reset_strobes got=%b exp=111", {ram_cs_b, uart_cs_b, s_rnw}); end
        checks++; if (s_addr !== 16'h0000) begin errors++; $display("FAIL reset_s_addr got=%h exp=0000", s_addr); end
        checks++; if (s_wdata !== 16'h0000) begin errors++; $display("FAIL reset_s_wdata got=%h exp=0000", s_wdata); end
        checks++; if ({m0_rdata, m1_rdata} !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=00000000", {m0_rdata, m1_rdata}); end
        // A clock edge with req high must not start a transfer while reset is held
        @(negedge clk);
        checks++; if (ram_cs_b !== 1'b1) begin errors++; $display("FAIL reset_held_ram_cs got=%b exp=1", ram_cs_b); end
        m0_req = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_ram_read();
        apply_reset();
        m0_addr = 16'h0010; m0_rnw = 1'b1; s_rdata = 16'h1234; m0_req = 1'b1;
        @(negedge clk);
        checks++; if (ram_cs_b !== 1'b0) begin errors++; $display("FAIL read_ram_cs got=%b exp=0", ram_cs_b); end
        checks++; if (uart_cs_b !== 1'b1) begin errors++; $display("FAIL read_uart_cs got=%b exp=1", uart_cs_b); end
        checks++; if (s_addr !== 16'h0010) begin errors++; $display("FAIL read_s_addr got=%h exp=0010", s_addr); end
        checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL read_early_ack got=%b exp=0", m0_ack); end
        @(negedge clk);
        checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL read_m0_ack got=%b exp=1", m0_ack); end
        checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL read_m1_ack got=%b exp=0", m1_ack); end
        checks++; if (m0_rdata !== 16'h1234) begin errors++; $display("FAIL read_rdata got=%h exp=1234", m0_rdata); end
        checks++; if (ram_cs_b !== 1'b1) begin errors++; $display("FAIL read_cs_one_cycle got=%b exp=1", ram_cs_b); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL read_bus_err got=%b exp=0", bus_err); end
        m0_req = 1'b0;
        @(negedge clk);
        checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL read_ack_pulse got=%b exp=0", m0_ack); end
    endtask

    // Both requesters held high: m0, m1, m0 with an IDLE cycle between transfers
    task automatic test_round_robin();
        apply_reset();
        m0_addr = 16'h0020; m0_rnw = 1'b1; m1_addr = 16'h0030; m1_rnw = 1'b1;
        s_rdata = 16'h1111; m0_req = 1'b1; m1_req = 1'b1;
        @(negedge clk);
        checks++; if (s_addr !== 16'h0020) begin errors++; $display("FAIL rr_first_m0 got=%h exp=0020", s_addr); end
        @(negedge clk);
        checks++; if ({m0_ack, m1_ack} !== 2'b10) begin errors++; $display("FAIL rr_ack_m0 got=%b exp=10", {m0_ack, m1_ack}); end
        @(negedge clk);
        checks++; if ({ram_cs_b, m0_ack, m1_ack} !== 3'b100) begin errors++; $display("FAIL rr_idle_gap got=%b exp=100", {ram_cs_b, m0_ack, m1_ack}); end
        @(negedge clk);
        checks++; if (s_addr !== 16'h0030) begin errors++; $display("FAIL rr_second_m1 got=%h exp=0030", s_addr); end
        @(negedge clk);
        checks++; if ({m0_ack, m1_ack} !== 2'b01) begin errors++; $display("FAIL rr_ack_m1 got=%b exp=01", {m0_ack, m1_ack}); end
        checks++; if (m1_rdata !== 16'h1111) begin errors++; $display("FAIL rr_m1_rdata got=%h exp=1111", m1_rdata); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (s_addr !== 16'h0020) begin errors++; $display("FAIL rr_third_m0 got=%h exp=0020", s_addr); end
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
    endtask

    // Starts in IDLE with m1_rdata = 1111 left by the round-robin test
    task automatic test_uart_write();
        m1_addr = 16'hFE09; m1_wdata = 16'h0041; m1_rnw = 1'b0; s_rdata = 16'hBEEF; m1_req = 1'b1;
        @(negedge clk);
        checks++; if (uart_cs_b !== 1'b0) begin errors++; $display("FAIL wr_uart_cs got=%b exp=0", uart_cs_b); end
        checks++; if (ram_cs_b !== 1'b1) begin errors++; $display("FAIL wr_ram_cs got=%b exp=1", ram_cs_b); end
        checks++; if (s_rnw !== 1'b0) begin errors++; $display("FAIL wr_s_rnw got=%b exp=0", s_rnw); end
        checks++; if (s_wdata !== 16'h0041) begin errors++; $display("FAIL wr_s_wdata got=%h exp=0041", s_wdata); end
        checks++; if (s_addr !== 16'hFE09) begin errors++; $display("FAIL wr_s_addr got=%h exp=FE09", s_addr); end
        @(negedge clk);
        checks++; if (m1_ack !== 1'b1) begin errors++; $display("FAIL wr_m1_ack got=%b exp=1", m1_ack); end
        checks++; if (m1_rdata !== 16'h1111) begin errors++; $display("FAIL wr_rdata_kept got=%h exp=1111", m1_rdata); end
        checks++; if ({uart_cs_b, s_rnw} !== 2'b11) begin errors++; $display("FAIL wr_done_strobes got=%b exp=11", {uart_cs_b, s_rnw}); end
        m1_req = 1'b0; m1_rnw = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unmapped();
        m0_addr = 16'h9000; m0_rnw = 1'b1; s_rdata = 16'h2222; m0_req = 1'b1;
        @(negedge clk);
        checks++; if ({ram_cs_b, uart_cs_b} !== 2'b11) begin errors++; $display("FAIL unm_no_cs got=%b exp=11", {ram_cs_b, uart_cs_b}); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL unm_early_err got=%b exp=0", bus_err); end
        @(negedge clk);
        checks++; if ({m0_ack, bus_err} !== 2'b11) begin errors++; $display("FAIL unm_ack_err got=%b exp=11", {m0_ack, bus_err}); end
        checks++; if (m0_rdata !== 16'hFFFF) begin errors++; $display("FAIL unm_rdata got=%h exp=FFFF", m0_rdata); end
        m0_req = 1'b0;
        @(negedge clk);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL unm_err_pulse got=%b exp=0", bus_err); end
    endtask

    // WAIT_CYCLES=3 instance: reset during the second ACCESS cycle, then restart
    task automatic test_reset_mid_access();
        apply_reset();
        m0_addr = 16'h0100; m0_rnw = 1'b1; s_rdata = 16'h5A5A; m0_req = 1'b1;
        @(negedge clk);
        checks++; if (ram_cs_b_3 !== 1'b0) begin errors++; $display("FAIL mid_access1 got=%b exp=0", ram_cs_b_3); end
        @(negedge clk);
        checks++; if (ram_cs_b_3 !== 1'b0) begin errors++; $display("FAIL mid_access2 got=%b exp=0", ram_cs_b_3); end
        reset = 1'b1;
        #1;
        checks++; if ({m0_ack_3, m1_ack_3, bus_err_3} !== 3'b000) begin errors++; $display("FAIL mid_rst_ack got=%b exp=000", {m0_ack_3, m1_ack_3, bus_err_3}); end
        checks++; if ({ram_cs_b_3, uart_cs_b_3, s_rnw_3} !== 3'b111) begin errors++; $display("FAIL mid_rst_strobes got=%b exp=111", {ram_cs_b_3, uart_cs_b_3, s_rnw_3}); end
        checks++; if ({s_addr_3, s_wdata_3} !== 32'h0) begin errors++; $display("FAIL mid_rst_bus got=%h exp=00000000", {s_addr_3, s_wdata_3}); end
        checks++; if ({m0_rdata_3, m1_rdata_3} !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata got=%h exp=00000000", {m0_rdata_3, m1_rdata_3}); end
        @(negedge clk);
        checks++; if (m0_ack_3 !== 1'b0) begin errors++; $display("FAIL mid_rst_no_ack got=%b exp=0", m0_ack_3); end
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                checks++; if ({ram_cs_b_3, m0_ack_3} !== 2'b00) begin errors++; $display("FAIL restart_access%0d got=%b exp=00", i, {ram_cs_b_3, m0_ack_3}); end
            end else begin
                checks++; if (m0_ack_3 !== 1'b1) begin errors++; $display("FAIL restart_ack got=%b exp=1", m0_ack_3); end
                checks++; if (m0_rdata_3 !== 16'h5A5A) begin errors++; $display("FAIL restart_rdata got=%h exp=5A5A", m0_rdata_3); end
            end
        end
        m0_req = 1'b0;
        @(negedge clk);
    endtask

`ifdef OPC_ARB_LOCK_EN
    // m1 keeps the bus while locked; lock dropped before its 4th ack hands the next grant to m0
    task automatic test_lock();
        logic [15:0] exp_addr [5];
        exp_addr = '{16'h0020, 16'h0030, 16'h0030, 16'h0030, 16'h0020};
        apply_reset();
        m0_addr = 16'h0020; m1_addr = 16'h0030; m0_rnw = 1'b1; m1_rnw = 1'b1;
        m1_lock = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if ((n % 3) == 1) begin
                checks++; if (s_addr !== exp_addr[(n - 1) / 3]) begin errors++; $display("FAIL lock_grant%0d got=%h exp=%h", (n - 1) / 3, s_addr, exp_addr[(n - 1) / 3]); end
                if ((n - 1) / 3 == 3) m1_lock = 1'b0;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_ram_read();
        test_round_robin();
        test_uart_write();
        test_unmapped();
        test_reset_mid_access();
`ifdef OPC_ARB_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
